// File: rtl/mdu_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | mdu_ctrl_pkg                                                          |
// | MDU operation and controller state encodings.                         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MFHI  = 3'd4,
        MDU_MFLO  = 3'd5,
        MDU_MTHI  = 3'd6,
        MDU_MTLO  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MUL       = 2'd1,
        ST_DIV_ISSUE = 2'd2,
        ST_DIV_WAIT  = 2'd3
    } mdu_state_e;

endpackage

`default_nettype wire

// File: rtl/mdu_sign_fix.sv
// +----------------------------------------------------------------------+
// | mdu_sign_fix                                                          |
// | Conditional two's-complement negate: magnitude in, sign restore out.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module mdu_sign_fix (
    input  logic [31:0] val_i,
    input  logic        neg_i,
    output logic [31:0] mag_o
);

    assign mag_o = neg_i ? (~val_i + 32'd1) : val_i;

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// +----------------------------------------------------------------------+
// | mdu_ctrl                                                              |
// | E-stage MUL/DIV controller: owns HI/LO, drives an external divider.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        stall,
    output logic        busy,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_start,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_busy,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo
);

    localparam int              CNT_W    = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULT_LAT - 1);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [63:0]      prod_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      div_a_q;
    logic [31:0]      div_b_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             div_start_q;
    logic             busy_q;

    mdu_op_e          op;
    logic             accept;
    logic             sdiv;
    logic             smul;
    logic [63:0]      prod_d;
    logic [31:0]      a_mag;
    logic [31:0]      b_mag;
    logic [31:0]      quo_d;
    logic [31:0]      rem_d;

    assign op     = mdu_op_e'(req_op);
    assign accept = req_valid && (state_q == ST_IDLE);
    assign sdiv   = (op == MDU_DIV);
    assign smul   = (op == MDU_MULT);

    // Low 64 bits of a 64x64 product of sign/zero-extended operands give
    // the correct signed or unsigned 32x32 result from one multiplier.
    assign prod_d = {{32{smul & rs_val[31]}}, rs_val} * {{32{smul & rt_val[31]}}, rt_val};

    mdu_sign_fix u_fix_a (.val_i(rs_val), .neg_i(sdiv & rs_val[31]), .mag_o(a_mag));
    mdu_sign_fix u_fix_b (.val_i(rt_val), .neg_i(sdiv & rt_val[31]), .mag_o(b_mag));
    mdu_sign_fix u_fix_q (.val_i(div_lo), .neg_i(qneg_q),            .mag_o(quo_d));
    mdu_sign_fix u_fix_r (.val_i(div_hi), .neg_i(rneg_q),            .mag_o(rem_d));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            prod_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            div_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            div_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        case (op)
                            MDU_MULT, MDU_MULTU: begin
                                prod_q  <= prod_d;
                                cnt_q   <= CNT_INIT;
                                busy_q  <= 1'b1;
                                state_q <= ST_MUL;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                // Divide by zero retires immediately, HI/LO untouched.
                                if (rt_val != 32'd0) begin
                                    qneg_q      <= sdiv & (rs_val[31] ^ rt_val[31]);
                                    rneg_q      <= sdiv & rs_val[31];
                                    div_a_q     <= a_mag;
                                    div_b_q     <= b_mag;
                                    div_start_q <= 1'b1;
                                    busy_q      <= 1'b1;
                                    state_q     <= ST_DIV_ISSUE;
                                end
                            end
                            MDU_MTHI: hi_q <= rs_val;
                            MDU_MTLO: lo_q <= rs_val;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (cnt_q == '0) begin
                        hi_q    <= prod_q[63:32];
                        lo_q    <= prod_q[31:0];
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DIV_ISSUE: begin
                    state_q <= ST_DIV_WAIT;
                end
                ST_DIV_WAIT: begin
                    if (!div_busy) begin
                        hi_q    <= rem_d;
                        lo_q    <= quo_d;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rd_data = 32'd0;
        if (accept) begin
            if (op == MDU_MFHI) begin
                rd_data = hi_q;
            end else if (op == MDU_MFLO) begin
                rd_data = lo_q;
            end
        end
    end

    assign stall     = req_valid && busy_q;
    assign busy      = busy_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign div_start = div_start_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_mdu_ctrl                                                           |
// | Randomized self-checking bench with a behavioural divider responder.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int MULT_LAT = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        stall;
    logic        busy;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_start;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_busy = 1'b0;
    logic [31:0] div_hi   = 32'd0;
    logic [31:0] div_lo   = 32'd0;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_starts = 0;
    int          force_lat = 0;
    int          dcnt = 0;
    logic [31:0] res_q, res_r;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    mdu_ctrl #(.MULT_LAT(MULT_LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .busy(busy),
        .rd_data(rd_data), .hi(hi), .lo(lo), .div_start(div_start),
        .div_a(div_a), .div_b(div_b), .div_busy(div_busy),
        .div_hi(div_hi), .div_lo(div_lo)
    );

    // Iterative unsigned divider stand-in with variable latency.
    always @(negedge clk) begin
        if (reset) begin
            div_busy = 1'b0;
            dcnt     = 0;
        end else if (div_start) begin
            div_busy = 1'b1;
            dcnt     = (force_lat > 0) ? force_lat : int'($urandom_range(1, 6));
            if (div_b != 32'd0) begin
                res_q = div_a / div_b;
                res_r = div_a % div_b;
            end
            n_starts++;
        end else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) begin
                div_busy = 1'b0;
                div_lo   = res_q;
                div_hi   = res_r;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of one MDU instruction on HI/LO.
    function automatic void model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        case (op)
            MDU_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            MDU_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            MDU_DIV: if (b != 32'd0) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = sa / sb;
                r  = sa % sb;
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            MDU_DIVU: if (b != 32'd0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            MDU_MTHI: m_hi = a;
            MDU_MTLO: m_lo = a;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one instruction from an idle unit and follow it to retirement.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int          cyc;
        int          s0;
        logic [31:0] ea, eb;
        logic        sgn;
        req_valid = 1'b1;
        req_op    = op;
        rs_val    = a;
        rt_val    = b;
        #1;
        chk("stall_idle", stall, 1'b0);
        if (op == MDU_MFHI)      chk("rd_mfhi", rd_data, m_hi);
        else if (op == MDU_MFLO) chk("rd_mflo", rd_data, m_lo);
        else                     chk("rd_other", rd_data, 32'd0);
        sgn = (op == MDU_DIV);
        ea  = (sgn && a[31]) ? -a : a;
        eb  = (sgn && b[31]) ? -b : b;
        s0  = n_starts;
        model_op(op, a, b);
        tick();
        req_valid = 1'b0;
        if (op == MDU_MULT || op == MDU_MULTU) begin
            cyc = 0;
            while (busy === 1'b1 && cyc < 200) begin
                cyc++;
                tick();
            end
            chk("mul_busy_cycles", cyc, MULT_LAT);
        end else if ((op == MDU_DIV || op == MDU_DIVU) && b != 32'd0) begin
            chk("div_start", div_start, 1'b1);
            chk("div_a", div_a, ea);
            chk("div_b", div_b, eb);
            cyc = 0;
            while (busy === 1'b1 && cyc < 200) begin
                cyc++;
                tick();
            end
            chk("div_done", cyc < 200, 1'b1);
            chk("div_a_held", div_a, ea);
            chk("div_pulses", n_starts - s0, 1);
        end else begin
            chk("busy_short_op", busy, 1'b0);
            chk("no_div_start", div_start, 1'b0);
        end
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    task automatic mult_then_mflo(input logic [31:0] a, input logic [31:0] b);
        int cyc;
        req_valid = 1'b1;
        req_op    = MDU_MULT;
        rs_val    = a;
        rt_val    = b;
        model_op(MDU_MULT, a, b);
        tick();
        req_op = MDU_MFLO;
        #1;
        cyc = 0;
        while (stall === 1'b1 && cyc < 200) begin
            cyc++;
            tick();
        end
        chk("mflo_stall_cycles", cyc, MULT_LAT);
        chk("mflo_after_stall", rd_data, m_lo);
        tick();
        req_valid = 1'b0;
        chk("mflo_hi", hi, m_hi);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        rs_val    = 32'd0;
        rt_val    = 32'd0;
        m_hi      = 32'd0;
        m_lo      = 32'd0;
        repeat (3) tick();
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_div_start", div_start, 1'b0);
        req_valid = 1'b1;
        req_op    = MDU_MFHI;
        #1;
        chk("rst_stall", stall, 1'b0);
        req_valid = 1'b0;
        reset     = 1'b0;
        tick();

        do_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7);
        chk("mult_hi_const", hi, 32'hFFFF_FFFF);
        chk("mult_lo_const", lo, 32'hFFFF_FFEB);
        do_op(MDU_MULTU, 32'hFFFF_FFFD, 32'd7);
        chk("multu_hi_const", hi, 32'h0000_0006);
        do_op(MDU_DIV, 32'hFFFF_FFEB, 32'd5);
        chk("div_lo_const", lo, 32'hFFFF_FFFC);
        chk("div_hi_const", hi, 32'hFFFF_FFFF);
        do_op(MDU_DIVU, 32'd21, 32'd5);
        chk("divu_lo_const", lo, 32'd4);
        chk("divu_hi_const", hi, 32'd1);
        do_op(MDU_MTHI, 32'h11, 32'd0);
        do_op(MDU_MTLO, 32'h22, 32'd0);
        do_op(MDU_DIV, 32'd5, 32'd0);
        chk("div0_hi_const", hi, 32'h11);
        do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("ovf_lo_const", lo, 32'h8000_0000);
        chk("ovf_hi_const", hi, 32'd0);
        do_op(MDU_MTHI, 32'hDEAD_BEEF, 32'd0);
        do_op(MDU_MFHI, 32'd0, 32'd0);
        mult_then_mflo(32'h0123_4567, 32'h89AB_CDEF);

        for (int i = 0; i < 80; i++) begin
            do_op(3'($urandom_range(0, 7)), pick(), pick());
        end

        // Abort a divide two cycles into the wait for the divider.
        do_op(MDU_MTHI, 32'h55, 32'd0);
        do_op(MDU_MTLO, 32'h66, 32'd0);
        force_lat = 30;
        req_valid = 1'b1;
        req_op    = MDU_DIV;
        rs_val    = 32'd100;
        rt_val    = 32'd7;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_hi", hi, m_hi);
        chk("abort_lo", lo, m_lo);
        req_valid = 1'b1;
        req_op    = MDU_MFLO;
        #1;
        chk("abort_stall", stall, 1'b0);
        req_valid = 1'b0;
        repeat (40) tick();
        chk("abort_no_commit_hi", hi, 32'd0);
        chk("abort_no_commit_lo", lo, 32'd0);
        chk("abort_idle", busy, 1'b0);
        force_lat = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
